key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the stable-level hold time in clk cycles (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 20, meaning the debounce counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port key_in, input, 1 bit: raw asynchronous key level, active-low, idle high.
REQ-006 The block SHALL have port key_stable, output, 1 bit: debounced registered level, which drives the downstream falling-edge detector's input_signal.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a level change is being qualified.
REQ-008 The block SHALL have port glitch_cnt, output, 8 bits: rejected-glitch count; the port exists only when KEY_DEBOUNCE_GLITCH_CNT_EN is defined.

Function
REQ-009 key_in SHALL pass through a two-flop synchronizer; key_sync is the second-stage output; no logic SHALL use key_in directly.
REQ-010 FSM states SHALL be S_HIGH, S_FALL, S_LOW and S_RISE; key_stable SHALL be 1 in S_HIGH and S_FALL, and 0 in S_LOW and S_RISE.
REQ-011 In S_HIGH with key_sync=0, the FSM SHALL go to S_FALL and set cnt=0; with key_sync=1, it SHALL stay.
REQ-012 In S_FALL with key_sync=1, the FSM SHALL return to S_HIGH (glitch) with cnt=0; otherwise cnt SHALL increment each cycle.
REQ-013 In S_FALL, when cnt==DEBOUNCE_CYCLES-1 and key_sync=0, the FSM SHALL go to S_LOW, key_stable SHALL become 0 at that edge, and cnt SHALL clear.
REQ-014 S_LOW and S_RISE SHALL behave symmetrically to S_HIGH and S_FALL with levels inverted; S_RISE SHALL exit to S_HIGH, with key_stable becoming 1.
REQ-015 Latency: key_stable SHALL change on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples a new steady key_in level.
REQ-016 A glitch on the final qualifying cycle (key_sync reverts when cnt==DEBOUNCE_CYCLES-1) SHALL abort the change: no key_stable change, and the FSM returns to its stable state.
REQ-017 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.
REQ-018 busy SHALL be registered and high exactly in S_FALL or S_RISE.
REQ-019 key_stable SHALL change at most once per DEBOUNCE_CYCLES cycles and SHALL never pulse for a single cycle.
REQ-020 DEBOUNCE_CYCLES SHALL be >=2 and <2**CNT_WIDTH; out-of-range values are illegal, and a simulation assertion SHALL flag them.

Reset
REQ-021 rst asserted SHALL immediately force both synchronizer flops=1, state=S_HIGH, cnt=0, key_stable=1, busy=0 and glitch_cnt=0.
REQ-022 rst asserted mid-qualification SHALL discard the pending change, with no key_stable pulse on release.
REQ-023 After rst deasserts, operation SHALL resume on the next clk rising edge.

Configuration
REQ-024 With KEY_DEBOUNCE_GLITCH_CNT_EN defined, every S_FALL->S_HIGH or S_RISE->S_LOW abort SHALL increment glitch_cnt, saturating at 255.
REQ-025 Without KEY_DEBOUNCE_GLITCH_CNT_EN, the glitch_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package key_debounce_pkg SHALL hold the state typedef (S_HIGH/S_FALL/S_LOW/S_RISE), the key idle-level constant (1'b1), and the glitch counter width constant (8).
REQ-027 The synchronizer SHALL be sub-module sync_2ff (1-bit, reset value parameter); no other sub-modules.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-028 The bench SHALL cover this case: after reset, key_in=1 held -> key_stable=1, busy=0, glitch_cnt=0 for 100 cycles.
REQ-029 The bench SHALL cover this case: key_in 1->0 held -> key_stable falls on the 7th edge after first sampling; busy high for exactly 4 cycles.
REQ-030 The bench SHALL cover this case: key_in low for 2 cycles then high -> key_stable stays 1 and glitch_cnt=1 (macro defined).
REQ-031 The bench SHALL cover this case: 300 consecutive glitches -> glitch_cnt saturates at 255.
REQ-032 The bench SHALL cover this case: rst asserted while in S_FALL with cnt=2 -> all outputs at reset values immediately, and key_stable stays 1 after release while key_in=1.
REQ-033 The bench SHALL cover this case: key_stable connected to the downstream falling-edge detector with enable=1, one clean press -> exactly one detected pulse.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer.
// Glitch counter width lives here so the optional KEY_DEBOUNCE_GLITCH_CNT_EN port can use it.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        S_HIGH = 2'd0,
        S_FALL = 2'd1,
        S_LOW  = 2'd2,
        S_RISE = 2'd3
    } state_e;

    localparam logic KEY_IDLE     = 1'b1;
    localparam int   GLITCH_CNT_W = 8;

    function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Both stages load RST_VAL on reset so the first sampled level is the idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low key: a new level must hold DEBOUNCE_CYCLES+1 synchronized samples.
// Optional rejected-glitch counter port is enabled by defining KEY_DEBOUNCE_GLITCH_CNT_EN.
//
// state  | meaning
// S_HIGH | key released, stable high
// S_FALL | low seen, qualifying a press
// S_LOW  | key pressed, stable low
// S_RISE | high seen, qualifying a release
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_stable,
    output logic busy
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) &&
                            (64'(DEBOUNCE_CYCLES) < (64'd1 << CNT_WIDTH));

    logic                 key_sync;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 key_stable_q, key_stable_d;
    logic                 busy_q, busy_d;

    sync_2ff #(
        .RST_VAL (KEY_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (key_in),
        .q_o (key_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter stops at CNT_LAST: that cycle either commits the new level or aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_HIGH: begin
                cnt_d = '0;
                if (!key_sync) state_d = S_FALL;
            end
            S_FALL: begin
                if (key_sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOW: begin
                cnt_d = '0;
                if (key_sync) state_d = S_RISE;
            end
            S_RISE: begin
                if (!key_sync) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_HIGH;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they flip on the same edge as the state.
    always_comb begin
        key_stable_d = (state_d == S_HIGH) || (state_d == S_FALL);
        busy_d       = (state_d == S_FALL) || (state_d == S_RISE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_stable_q <= KEY_IDLE;
            busy_q       <= 1'b0;
        end else begin
            key_stable_q <= key_stable_d;
            busy_q       <= busy_d;
        end
    end

    assign key_stable = key_stable_q;
    assign busy       = busy_q;

`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    logic                    abort;
    logic [GLITCH_CNT_W-1:0] glitch_q;

    assign abort = ((state_q == S_FALL) &&  key_sync) ||
                   ((state_q == S_RISE) && !key_sync);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (abort) begin
            glitch_q <= sat_inc(glitch_q);
        end
    end

    assign glitch_cnt = glitch_q;
`endif

    always_ff @(posedge clk) begin
        assert (CFG_OK)
            else $error("key_debounce: DEBOUNCE_CYCLES=%0d illegal for CNT_WIDTH=%0d",
                        DEBOUNCE_CYCLES, CNT_WIDTH);
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model predicts key_stable edges,
// busy and glitch count; a negedge monitor compares them against the DUT.
module tb_key_debounce;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic key_stable;
    logic busy;
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .CNT_WIDTH       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_stable (key_stable),
        .busy       (busy)
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: key_stable flips after D+1 consecutive synchronized samples that differ
    // from it; any matching sample in between abandons the attempt (a glitch).
    typedef struct {
        bit          v;
        int unsigned cyc;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned cycle = 0;
    bit          pipe[2];
    int          run;
    bit          m_stable;
    int          m_glitch;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe[0] = 1'b1;
            pipe[1] = 1'b1;
            run = 0;
            m_stable = 1'b1;
            m_glitch = 0;
            exp_q.delete();
        end else begin
            bit obs;
            cycle++;
            obs = pipe[0];
            pipe[0] = pipe[1];
            pipe[1] = key_in;
            if (obs != m_stable) begin
                run++;
                if (run == D + 1) begin
                    m_stable = ~m_stable;
                    run = 0;
                    exp_q.push_back('{v: m_stable, cyc: cycle});
                end
            end else begin
                if (run > 0 && m_glitch < 255) m_glitch++;
                run = 0;
            end
        end
    end

    bit prev_ks = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            prev_ks = 1'b1;
        end else begin
            if (key_stable !== prev_ks) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_edge", key_stable, prev_ks);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("edge_value", key_stable, e.v);
                    chk("edge_cycle", cycle, e.cyc);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cycle) begin
                ev_t e;
                e = exp_q.pop_front();
                chk("missed_edge", key_stable, e.v);
            end
            prev_ks = key_stable;
            chk("busy", busy, run != 0);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
            chk("glitch_cnt", glitch_cnt, m_glitch);
`endif
        end
    end

    // Downstream falling-edge detector fed by key_stable.
    logic enable;
    logic det_prev;
    logic det_pulse;
    int   det_count = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) det_prev <= 1'b1;
        else     det_prev <= key_stable;
    end

    assign det_pulse = enable & det_prev & ~key_stable;

    always @(negedge clk) begin
        if (!rst && det_pulse) det_count++;
    end

    task automatic hold(input bit v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int          nb;
        bit          found;
        int          p0;

        rst    = 1'b1;
        key_in = 1'b1;
        enable = 1'b1;
        #3;
        chk("rst_key_stable", key_stable, 1);
        chk("rst_busy", busy, 0);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        chk("rst_glitch_cnt", glitch_cnt, 0);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        hold(1'b1, 100);
        chk("idle_key_stable", key_stable, 1);
        chk("idle_busy", busy, 0);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        chk("idle_glitch_cnt", glitch_cnt, 0);
`endif

        c0     = cycle;
        key_in = 1'b0;
        nb     = 0;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (!key_stable) found = 1'b1;
        end
        chk("fall_found", found, 1);
        chk("fall_latency", cycle - c0, D + 3);
        chk("fall_busy_cycles", nb, D);
        hold(1'b0, 10);
        hold(1'b1, 20);
        chk("release_key_stable", key_stable, 1);

        hold(1'b0, 2);
        hold(1'b1, 15);
        chk("short_glitch_key_stable", key_stable, 1);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        chk("short_glitch_cnt", glitch_cnt, 1);
`endif

        hold(1'b0, D);
        hold(1'b1, 15);
        chk("last_cycle_abort_key_stable", key_stable, 1);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        chk("last_cycle_abort_glitch_cnt", glitch_cnt, 2);
`endif
        hold(1'b0, D + 1);
        hold(1'b1, 2);
        chk("min_press_key_stable", key_stable, 0);
        hold(1'b1, 20);
        chk("min_press_release", key_stable, 1);

        key_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_key_stable", key_stable, 1);
        chk("mid_rst_busy", busy, 0);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        chk("mid_rst_glitch_cnt", glitch_cnt, 0);
`endif
        @(negedge clk);
        key_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 20);
        chk("post_rst_key_stable", key_stable, 1);

        for (int i = 0; i < 300; i++) begin
            hold(1'b0, 1);
            hold(1'b1, 3);
        end
        chk("glitch_storm_key_stable", key_stable, 1);
`ifdef KEY_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_saturate", glitch_cnt, 255);
`endif

        hold(1'b1, 10);
        p0 = det_count;
        hold(1'b0, 20);
        hold(1'b1, 20);
        chk("detector_pulses", det_count - p0, 1);

        repeat (400) hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
        hold(1'b1, 20);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_key_stable", key_stable, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
